// File: rtl/pipeline_multi.sv
// rtl/pipeline_multi.sv - one-hot steered multi-port flit buffer with per-port FWFT FIFOs
module pipeline_multi #(
    parameter int DW       = 7,
    parameter int NP       = 4,
    parameter int DEPTH    = 5,
    parameter int LOCKSTEP = 0,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      in_data,
    input  logic [NP-1:0]      in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NP*DW-1:0]   out_data,
    output logic [NP-1:0]      out_valid,
    input  logic [NP-1:0]      out_ready,
    output logic [NP*CW-1:0]   occ,
    output logic               err_sel
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] cnt    [NP];
    logic [PW-1:0] wr_ptr [NP];
    logic [PW-1:0] rd_ptr [NP];
    logic [DW-1:0] mem    [NP][DEPTH];

    logic          sel_onehot;
    logic          sel_full;
    logic [NP-1:0] nonempty;
    logic [NP-1:0] push;
    logic [NP-1:0] pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] v);
        return (v == PW'(DEPTH - 1)) ? '0 : v + PW'(1);
    endfunction

    always_comb begin
        sel_full = 1'b0;
        nonempty = '0;
        for (int p = 0; p < NP; p++) begin
            nonempty[p] = (cnt[p] != '0);
            if (in_sel[p] && (cnt[p] == CW'(DEPTH)))
                sel_full = 1'b1;
        end
    end

    assign sel_onehot = (in_sel != '0) && ((in_sel & (in_sel - NP'(1))) == '0);
    assign in_ready   = sel_onehot && !sel_full;
    assign push       = (in_valid && in_ready) ? in_sel : '0;

    // In lockstep mode a port only presents its head once every port has one.
    assign out_valid  = (LOCKSTEP != 0) ? {NP{&nonempty}} : nonempty;
    assign pop        = (LOCKSTEP != 0) ? {NP{(&out_valid) && (&out_ready)}}
                                        : (out_valid & out_ready);

    for (genvar g = 0; g < NP; g++) begin : g_port
        assign out_data[g*DW +: DW] = out_valid[g] ? mem[g][rd_ptr[g]] : '0;
        assign occ[g*CW +: CW]      = cnt[g];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel <= 1'b0;
            for (int p = 0; p < NP; p++) begin
                cnt[p]    <= '0;
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            err_sel <= in_valid && !sel_onehot;
            for (int p = 0; p < NP; p++) begin
                if (push[p])
                    wr_ptr[p] <= bump(wr_ptr[p]);
                if (pop[p])
                    rd_ptr[p] <= bump(rd_ptr[p]);
                if (push[p] && !pop[p])
                    cnt[p] <= cnt[p] + CW'(1);
                else if (pop[p] && !push[p])
                    cnt[p] <= cnt[p] - CW'(1);
            end
        end
    end

    // Storage is never reset; out_data masking hides stale slots.
    always_ff @(posedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (push[p])
                mem[p][wr_ptr[p]] <= in_data;
        end
    end
endmodule

// File: tb/tb_pipeline_multi.sv
// tb/tb_pipeline_multi.sv - directed plus randomized checks of pipeline_multi against a queue model
module tb_pipeline_multi;
    localparam int DW    = 7;
    localparam int NP    = 4;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst_n;
    logic [DW-1:0]      in_data;
    logic [NP-1:0]      in_sel;
    logic               in_valid;
    logic               in_ready;
    logic [NP*DW-1:0]   out_data;
    logic [NP-1:0]      out_valid;
    logic [NP-1:0]      out_ready;
    logic [NP*CW-1:0]   occ;
    logic               err_sel;

    logic [DW-1:0]      l_in_data;
    logic [NP-1:0]      l_in_sel;
    logic               l_in_valid;
    logic               l_in_ready;
    logic [NP*DW-1:0]   l_out_data;
    logic [NP-1:0]      l_out_valid;
    logic [NP-1:0]      l_out_ready;
    logic [NP*CW-1:0]   l_occ;
    logic               l_err_sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] q [NP][$];
    logic          err_exp;

    pipeline_multi #(.DW(DW), .NP(NP), .DEPTH(DEPTH), .LOCKSTEP(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .occ(occ), .err_sel(err_sel)
    );

    pipeline_multi #(.DW(DW), .NP(NP), .DEPTH(DEPTH), .LOCKSTEP(1)) dut_lock (
        .clk(clk), .rst_n(rst_n), .in_data(l_in_data), .in_sel(l_in_sel),
        .in_valid(l_in_valid), .in_ready(l_in_ready), .out_data(l_out_data),
        .out_valid(l_out_valid), .out_ready(l_out_ready), .occ(l_occ), .err_sel(l_err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        for (int p = 0; p < NP; p++) begin
            chk($sformatf("occ[%0d]", p), 32'(occ[p*CW +: CW]), 32'(q[p].size()));
            chk($sformatf("out_valid[%0d]", p), 32'(out_valid[p]), 32'(q[p].size() > 0));
            chk($sformatf("out_data[%0d]", p), 32'(out_data[p*DW +: DW]),
                (q[p].size() > 0) ? 32'(q[p][0]) : 32'd0);
        end
        chk("err_sel", 32'(err_sel), 32'(err_exp));
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++) q[p].delete();
        err_exp = 1'b0;
    endtask

    // Drive one cycle of stimulus, predict in_ready, advance the model at the edge, then check.
    task automatic step(input logic v, input logic [NP-1:0] sel, input logic [DW-1:0] d,
                        input logic [NP-1:0] rdy);
        logic oh;
        logic full;
        logic exp_rdy;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = rdy;
        #1;
        oh   = ($countones(sel) == 1);
        full = 1'b0;
        for (int p = 0; p < NP; p++)
            if (sel[p] && q[p].size() == DEPTH) full = 1'b1;
        exp_rdy = oh && !full;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        for (int p = 0; p < NP; p++) begin
            if (rdy[p] && q[p].size() > 0) void'(q[p].pop_front());
            if (v && exp_rdy && sel[p]) q[p].push_back(d);
        end
        err_exp = v && !oh;
        #1;
        chk_state();
    endtask

    task automatic lstep(input logic v, input logic [NP-1:0] sel, input logic [DW-1:0] d,
                         input logic [NP-1:0] rdy);
        l_in_valid  = v;
        l_in_sel    = sel;
        l_in_data   = d;
        l_out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NP-1:0] rsel;
        rst_n = 1'b0;
        in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
        l_in_valid = 1'b0; l_in_sel = '0; l_in_data = '0; l_out_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_state();
        chk("reset in_ready sel=0", 32'(in_ready), 32'd0);
        rst_n = 1'b1;

        // Two pushes to ports 0 and 1, nothing drained
        step(1'b1, 4'b0001, 7'h11, 4'b0000);
        step(1'b1, 4'b0010, 7'h22, 4'b0000);
        step(1'b0, 4'b0000, 7'h00, 4'b0000);
        chk("occ after 2 pushes", 32'(occ), 32'({3'd0, 3'd0, 3'd1, 3'd1}));
        chk("out_valid after 2 pushes", 32'(out_valid), 32'(4'b0011));
        step(1'b0, 4'b0000, 7'h00, 4'b1111);

        // Overfill port 2
        for (int i = 0; i < 6; i++)
            step(1'b1, 4'b0100, 7'(8'h30 + i), 4'b0000);
        chk("port2 full occ", 32'(occ[2*CW +: CW]), 32'd5);
        chk("port2 full in_ready", 32'(in_ready), 32'd0);
        chk("port2 full no err", 32'(err_sel), 32'd0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 4'b0000, 7'h00, 4'b0100);

        // Bad selects flag err_sel for one cycle each
        step(1'b1, 4'b0101, 7'h7f, 4'b0000);
        chk("err after 0101", 32'(err_sel), 32'd1);
        step(1'b1, 4'b0000, 7'h7e, 4'b0000);
        chk("err after 0000", 32'(err_sel), 32'd1);
        step(1'b0, 4'b0000, 7'h00, 4'b0000);
        chk("err cleared", 32'(err_sel), 32'd0);

        // Port 3: full push+pop pops only, then a wrap-around stream at occ=2
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'b1000, 7'(8'h40 + i), 4'b0000);
        step(1'b1, 4'b1000, 7'h4f, 4'b1000);
        chk("port3 full push+pop occ", 32'(occ[3*CW +: CW]), 32'd4);
        step(1'b0, 4'b0000, 7'h00, 4'b1000);
        step(1'b0, 4'b0000, 7'h00, 4'b1000);
        for (int i = 0; i < 12; i++)
            step(1'b1, 4'b1000, 7'(8'h50 + i), 4'b1000);
        chk("port3 stream occ", 32'(occ[3*CW +: CW]), 32'd2);

        // Asynchronous reset between edges with flits stored
        step(1'b1, 4'b0001, 7'h61, 4'b0000);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_state();
        chk("async reset out_data", 32'(out_data), 32'd0);
        chk("async reset occ", 32'(occ), 32'd0);
        #1;
        rst_n = 1'b1;
        step(1'b1, 4'b0001, 7'h5a, 4'b0000);
        chk("post-reset head", 32'(out_data[0 +: DW]), 32'h5a);
        chk("post-reset occ", 32'(occ), 32'd1);
        step(1'b0, 4'b0000, 7'h00, 4'b0001);

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) < 8) rsel = NP'(1) << $urandom_range(0, NP - 1);
            else                          rsel = NP'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, rsel, 7'($urandom), NP'($urandom_range(0, 15)));
        end
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 4'b0000, 7'h00, 4'b1111);

        // Lockstep instance
        lstep(1'b1, 4'b0001, 7'h01, 4'b0000);
        lstep(1'b1, 4'b0010, 7'h02, 4'b0000);
        lstep(1'b1, 4'b0100, 7'h03, 4'b0000);
        lstep(1'b0, 4'b0000, 7'h00, 4'b1111);
        chk("lock valid port3 empty", 32'(l_out_valid), 32'd0);
        chk("lock occ no pop", 32'(l_occ), 32'({3'd0, 3'd1, 3'd1, 3'd1}));
        chk("lock data masked", 32'(l_out_data), 32'd0);
        lstep(1'b1, 4'b1000, 7'h04, 4'b1111);
        chk("lock valid all", 32'(l_out_valid), 32'(4'b1111));
        chk("lock occ all one", 32'(l_occ), 32'({3'd1, 3'd1, 3'd1, 3'd1}));
        chk("lock data heads", 32'(l_out_data), 32'({7'h04, 7'h03, 7'h02, 7'h01}));
        lstep(1'b0, 4'b0000, 7'h00, 4'b1111);
        chk("lock pop all occ", 32'(l_occ), 32'd0);
        chk("lock pop all valid", 32'(l_out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
